// File: rtl/vga_axi_pkg.sv
// Shared AXI read-channel encodings, FSM state type and the beat-address advance
// helper used by the read responder and the fetcher bench.
package vga_axi_pkg;

   localparam int unsigned MAX_AW = 64;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   // Per-beat side-band carried next to the data word through the R buffer.
   typedef struct packed {
      logic [1:0] resp;
      logic       last;
   } r_meta_t;

   // Address of the beat following addr; WRAP stays inside a (len+1)<<size aligned block.
   function automatic logic [MAX_AW-1:0] beat_addr_next(
      input logic [MAX_AW-1:0] addr,
      input logic [1:0]        burst,
      input logic [7:0]        len,
      input logic [2:0]        size
   );
      logic [MAX_AW-1:0] step;
      logic [MAX_AW-1:0] mask;
      logic [MAX_AW-1:0] incr;
      logic [MAX_AW-1:0] res;
      step = MAX_AW'(1) << size;
      mask = ((MAX_AW'(len) + MAX_AW'(1)) << size) - MAX_AW'(1);
      incr = addr + step;
      res  = incr;
      if (burst == BURST_FIXED) begin
         res = addr;
      end else if (burst == BURST_WRAP) begin
         res = (addr & ~mask) | (incr & mask);
      end
      return res;
   endfunction

endpackage

// File: rtl/vga_axi_rd_slave_if.sv
// AR/R channel bundle between the VGA frame fetcher (master) and the frame store (slave).
interface vga_axi_rd_slave_if #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64
);
   logic                  arvalid_i;
   logic                  arready_o;
   logic [ADDR_WIDTH-1:0] araddr_i;
   logic [1:0]            arburst_i;
   logic [7:0]            arlen_i;
   logic [2:0]            arsize_i;
   logic                  rvalid_o;
   logic                  rready_i;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic [1:0]            rresp_o;
   logic                  rlast_o;

   modport slave (
      input  arvalid_i, araddr_i, arburst_i, arlen_i, arsize_i, rready_i,
      output arready_o, rvalid_o, rdata_o, rresp_o, rlast_o
   );

   modport master (
      output arvalid_i, araddr_i, arburst_i, arlen_i, arsize_i, rready_i,
      input  arready_o, rvalid_o, rdata_o, rresp_o, rlast_o
   );
endinterface

// File: rtl/vga_axi_rd_fifo.sv
// Two-entry synchronous FIFO holding R beats; occupancy is exported for the issue logic.
module vga_axi_rd_fifo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_count
);
   logic [WIDTH-1:0] r_mem [2];
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= ~r_wptr;
         end
         if (i_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rptr];
   assign o_count = r_count;
endmodule

// File: rtl/vga_axi_rd_slave.sv
// AXI4 read responder serving FIXED/INCR/WRAP bursts from a single-port synchronous
// frame memory, with window decode (DECERR), request checks (SLVERR) and R back-pressure.
module vga_axi_rd_slave
   import vga_axi_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned MEM_AW     = 16
) (
   input  logic                  clk_a,
   input  logic                  resetn_a,
   input  logic [ADDR_WIDTH-1:0] win_base_i,
   input  logic [ADDR_WIDTH-1:0] win_top_i,
   vga_axi_rd_slave_if.slave     s_axi,
   output logic                  mem_en_o,
   output logic [MEM_AW-1:0]     mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
   localparam int unsigned LOG2B = $clog2(DATA_WIDTH / 8);
   localparam int unsigned MW    = $bits(r_meta_t);
   localparam int unsigned FW    = DATA_WIDTH + MW;

   state_e                r_state;
   state_e                w_state_n;
   logic                  r_arready;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic                  r_req_err;
   logic [8:0]            r_cnt;
   logic                  r_infl;
   r_meta_t               r_infl_meta;

   logic                  w_hs;
   logic                  w_issue;
   logic                  w_pop;
   logic                  w_rvalid;
   logic                  w_room;
   logic                  w_dec_err;
   logic                  w_req_err;
   logic [1:0]            w_resp;
   logic [1:0]            w_fifo_count;
   logic [FW-1:0]         w_push_data;
   logic [FW-1:0]         w_head;
   r_meta_t               w_head_meta;
   logic [DATA_WIDTH-1:0] w_push_rdata;
   logic [ADDR_WIDTH-1:0] w_off;

   assign w_req_err = (s_axi.arburst_i == BURST_RSVD)
                    || (s_axi.arsize_i > 3'(LOG2B))
                    || ((s_axi.arburst_i == BURST_WRAP)
                        && !(s_axi.arlen_i inside {8'd1, 8'd3, 8'd7, 8'd15}));

   assign w_rvalid  = (w_fifo_count != 2'd0);
   assign w_pop     = w_rvalid && s_axi.rready_i;
   // Buffered + in-flight beats after this cycle's pop must leave a free slot.
   assign w_room    = ({1'b0, w_fifo_count} + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop});
   assign w_dec_err = (r_addr < win_base_i) || (r_addr > win_top_i);
   assign w_off     = r_addr - win_base_i;

   always_comb begin
      w_state_n = r_state;
      w_hs      = 1'b0;
      w_issue   = 1'b0;
      w_resp    = RESP_OKAY;
      if (r_req_err) begin
         w_resp = RESP_SLVERR;
      end else if (w_dec_err) begin
         w_resp = RESP_DECERR;
      end
      case (r_state)
         ST_IDLE: begin
            if (s_axi.arvalid_i && r_arready) begin
               w_hs      = 1'b1;
               w_state_n = ST_BURST;
            end
         end
         ST_BURST: begin
            w_issue = (r_cnt <= {1'b0, r_len}) && w_room;
            if (w_pop && w_head_meta.last) begin
               w_state_n = ST_IDLE;
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_a or negedge resetn_a) begin
      if (!resetn_a) begin
         r_state   <= ST_IDLE;
         r_arready <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_arready <= (w_state_n == ST_IDLE);
      end
   end

   // Burst context and the one-beat memory-latency stage.
   always_ff @(posedge clk_a or negedge resetn_a) begin
      if (!resetn_a) begin
         r_addr      <= '0;
         r_len       <= 8'd0;
         r_size      <= 3'd0;
         r_burst     <= 2'd0;
         r_req_err   <= 1'b0;
         r_cnt       <= 9'd0;
         r_infl      <= 1'b0;
         r_infl_meta <= '0;
      end else begin
         if (w_hs) begin
            r_addr    <= s_axi.araddr_i;
            r_len     <= s_axi.arlen_i;
            r_size    <= s_axi.arsize_i;
            r_burst   <= s_axi.arburst_i;
            r_req_err <= w_req_err;
            r_cnt     <= 9'd0;
         end else if (w_issue) begin
            r_addr <= ADDR_WIDTH'(beat_addr_next(MAX_AW'(r_addr), r_burst, r_len, r_size));
            r_cnt  <= r_cnt + 9'd1;
         end
         r_infl           <= w_issue;
         r_infl_meta.resp <= w_resp;
         r_infl_meta.last <= (r_cnt == {1'b0, r_len});
      end
   end

   assign mem_en_o   = w_issue && (w_resp == RESP_OKAY);
   assign mem_addr_o = mem_en_o ? MEM_AW'(w_off >> LOG2B) : '0;

   assign w_push_rdata = (r_infl_meta.resp == RESP_OKAY) ? mem_rdata_i : '0;
   assign w_push_data  = {w_push_rdata, r_infl_meta};

   vga_axi_rd_fifo #(
      .WIDTH (FW)
   ) u_fifo (
      .i_clk   (clk_a),
      .i_rst_n (resetn_a),
      .i_push  (r_infl),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (w_fifo_count)
   );

   assign w_head_meta = r_meta_t'(w_head[MW-1:0]);

   assign s_axi.arready_o = r_arready;
   assign s_axi.rvalid_o  = w_rvalid;
   assign s_axi.rdata_o   = w_rvalid ? w_head[FW-1 -: DATA_WIDTH] : '0;
   assign s_axi.rresp_o   = w_rvalid ? w_head_meta.resp : 2'b00;
   assign s_axi.rlast_o   = w_rvalid && w_head_meta.last;
endmodule

// File: tb/tb_vga_axi_rd_slave.sv
// Self-checking bench for vga_axi_rd_slave: burst table with a beat scoreboard,
// plus hand-written back-pressure and mid-burst reset sequences.
module tb_vga_axi_rd_slave;
   import vga_axi_pkg::*;

   localparam int unsigned AW  = 64;
   localparam int unsigned DW  = 64;
   localparam int unsigned MAW = 16;
   localparam logic [63:0] WIN_BASE = 64'h1000;
   localparam logic [63:0] WIN_TOP  = 64'h1FFF;

   typedef struct {
      logic [63:0] addr;
      logic [1:0]  burst;
      logic [7:0]  len;
      logic [2:0]  size;
      bit          stall;
      int          exp_memen;
      logic [1:0]  exp_resp0;
      logic [63:0] exp_data0;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   logic           clk_a = 1'b0;
   logic           resetn_a;
   logic [AW-1:0]  win_base;
   logic [AW-1:0]  win_top;
   logic           mem_en;
   logic [MAW-1:0] mem_addr;
   logic [DW-1:0]  mem_rdata;

   vga_axi_rd_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   vga_axi_rd_slave #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_AW     (MAW)
   ) dut (
      .clk_a       (clk_a),
      .resetn_a    (resetn_a),
      .win_base_i  (win_base),
      .win_top_i   (win_top),
      .s_axi       (axi.slave),
      .mem_en_o    (mem_en),
      .mem_addr_o  (mem_addr),
      .mem_rdata_i (mem_rdata)
   );

   always #5 clk_a = ~clk_a;

   // Frame memory model: word k holds k, one-cycle read latency.
   always @(posedge clk_a) if (mem_en) mem_rdata <= DW'(mem_addr);

   int cyc = 0;
   always @(posedge clk_a) cyc <= cyc + 1;

   beat_t       exp_q[$];
   logic [15:0] mem_q[$];
   int          checks = 0;
   int          errors = 0;
   string       cur_tag = "reset";
   bit          mon_en = 1'b0;
   int          memen_cnt, pops, max_occ, first_rv_cyc;
   bit          got_first, prev_stall;
   logic [1:0]  first_resp;
   logic [63:0] first_data;
   logic [63:0] prev_data;
   logic [2:0]  prev_side;
   vec_t        vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_tag, name, act, exp);
      end
   endtask

   // Reference beat sequence computed from the burst rules.
   task automatic push_expected(input vec_t v);
      logic [63:0] a, step, span, base;
      bit          rerr;
      beat_t       b;
      a    = v.addr;
      step = 64'd1 << v.size;
      span = (64'(v.len) + 64'd1) << v.size;
      rerr = (v.burst == 2'b11) || (v.size > 3'd3) ||
             (v.burst == 2'b10 && !(v.len == 8'd1 || v.len == 8'd3 || v.len == 8'd7 || v.len == 8'd15));
      for (int i = 0; i <= int'(v.len); i++) begin
         b.last = (i == int'(v.len));
         if (rerr) begin
            b.resp = 2'b10; b.data = 64'd0;
         end else if (a < WIN_BASE || a > WIN_TOP) begin
            b.resp = 2'b11; b.data = 64'd0;
         end else begin
            b.resp = 2'b00; b.data = (a - WIN_BASE) >> 3;
            mem_q.push_back(16'((a - WIN_BASE) >> 3));
         end
         exp_q.push_back(b);
         if (v.burst == 2'b01) begin
            a = a + step;
         end else if (v.burst == 2'b10) begin
            base = a - (a % span);
            a    = base + ((a - base + step) % span);
         end
      end
   endtask

   always @(negedge clk_a) begin
      if (mon_en) begin
         bit    popnow;
         int    occ;
         beat_t e;
         popnow = axi.rvalid_o && axi.rready_i;
         if (mem_en) begin
            memen_cnt++;
            if (mem_q.size() == 0) chk("mem_en_unexpected", 64'd1, 64'd0);
            else chk("mem_addr", 64'(mem_addr), 64'(mem_q.pop_front()));
         end
         occ = memen_cnt - pops - (popnow ? 1 : 0);
         if (occ > max_occ) max_occ = occ;
         if (prev_stall) begin
            chk("stall_valid", 64'(axi.rvalid_o), 64'd1);
            chk("stall_data", axi.rdata_o, prev_data);
            chk("stall_side", 64'({axi.rresp_o, axi.rlast_o}), 64'(prev_side));
         end
         prev_stall = axi.rvalid_o && !axi.rready_i;
         prev_data  = axi.rdata_o;
         prev_side  = {axi.rresp_o, axi.rlast_o};
         if (axi.rvalid_o && !got_first) begin
            got_first    = 1'b1;
            first_rv_cyc = cyc;
            first_resp   = axi.rresp_o;
            first_data   = axi.rdata_o;
         end
         if (popnow) begin
            pops++;
            if (exp_q.size() == 0) begin
               chk("r_unexpected", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rdata", axi.rdata_o, e.data);
               chk("rresp", 64'(axi.rresp_o), 64'(e.resp));
               chk("rlast", 64'(axi.rlast_o), 64'(e.last));
            end
         end
      end
   end

   function automatic logic pat(input int ph);
      return (ph % 4 == 0) || (ph % 4 == 3);
   endfunction

   task automatic drive_ar(input vec_t v);
      axi.arvalid_i = 1'b1;
      axi.araddr_i  = v.addr;
      axi.arburst_i = v.burst;
      axi.arlen_i   = v.len;
      axi.arsize_i  = v.size;
   endtask

   task automatic run_vec(input vec_t v);
      int hs_cyc, guard, ph;
      memen_cnt = 0; pops = 0; max_occ = 0; got_first = 1'b0; prev_stall = 1'b0;
      push_expected(v);
      @(posedge clk_a); #1;
      chk("arready_idle", 64'(axi.arready_o), 64'd1);
      drive_ar(v);
      ph = 0;
      axi.rready_i = 1'b1;
      @(posedge clk_a); #1;
      hs_cyc = cyc;
      axi.arvalid_i = 1'b0;
      chk("arready_busy", 64'(axi.arready_o), 64'd0);
      ph = 1;
      axi.rready_i = v.stall ? pat(ph) : 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         @(posedge clk_a); #1;
         ph++;
         axi.rready_i = v.stall ? pat(ph) : 1'b1;
         guard++;
      end
      if (guard >= 300) begin
         chk("timeout", 64'd0, 64'd1);
         exp_q.delete();
         mem_q.delete();
      end else begin
         chk("arready_after_last", 64'(axi.arready_o), 64'd1);
         chk("rvalid_after_last", 64'(axi.rvalid_o), 64'd0);
      end
      chk("memen_count", 64'(memen_cnt), 64'(v.exp_memen));
      chk("first_rvalid_cycle", 64'(first_rv_cyc), 64'(hs_cyc + 2));
      chk("first_rresp", 64'(first_resp), 64'(v.exp_resp0));
      chk("first_rdata", first_data, v.exp_data0);
      chk("max_buffered", 64'(max_occ <= 2), 64'd1);
      chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_arready", 64'(axi.arready_o), 64'd0);
      chk("rst_rvalid", 64'(axi.rvalid_o), 64'd0);
      chk("rst_rlast", 64'(axi.rlast_o), 64'd0);
      chk("rst_rresp", 64'(axi.rresp_o), 64'd0);
      chk("rst_rdata", axi.rdata_o, 64'd0);
      chk("rst_mem_en", 64'(mem_en), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int guard;
      vecs[0] = '{64'h1000, 2'b01, 8'd3, 3'd3, 1'b0, 4, 2'b00, 64'd0};
      vecs[1] = '{64'h1010, 2'b10, 8'd3, 3'd3, 1'b0, 4, 2'b00, 64'd2};
      vecs[2] = '{64'h1FF8, 2'b01, 8'd1, 3'd3, 1'b0, 1, 2'b00, 64'h1FF};
      vecs[3] = '{64'h1000, 2'b11, 8'd2, 3'd3, 1'b0, 0, 2'b10, 64'd0};
      vecs[4] = '{64'h1000, 2'b01, 8'd1, 3'd4, 1'b0, 0, 2'b10, 64'd0};
      vecs[5] = '{64'h1000, 2'b01, 8'd7, 3'd3, 1'b1, 8, 2'b00, 64'd0};
      vecs[6] = '{64'h1008, 2'b00, 8'd2, 3'd3, 1'b0, 3, 2'b00, 64'd1};
      vecs[7] = '{64'h1000, 2'b10, 8'd2, 3'd3, 1'b0, 0, 2'b10, 64'd0};
      vecs[8] = '{64'h0FF8, 2'b01, 8'd1, 3'd3, 1'b0, 1, 2'b11, 64'd0};
      vecs[9] = '{64'h1038, 2'b10, 8'd7, 3'd2, 1'b0, 8, 2'b00, 64'd7};

      resetn_a      = 1'b0;
      win_base      = WIN_BASE;
      win_top       = WIN_TOP;
      axi.arvalid_i = 1'b0;
      axi.araddr_i  = '0;
      axi.arburst_i = 2'b00;
      axi.arlen_i   = 8'd0;
      axi.arsize_i  = 3'd0;
      axi.rready_i  = 1'b0;
      repeat (3) @(negedge clk_a);
      chk_reset_outputs();
      resetn_a = 1'b1;
      @(posedge clk_a); #1;
      chk("arready_after_reset", 64'(axi.arready_o), 64'd1);
      mon_en = 1'b1;

      for (int i = 0; i < 10; i++) begin
         cur_tag = $sformatf("vec%0d", i);
         run_vec(vecs[i]);
      end

      // Reset asserted while an 8-beat burst is in progress.
      cur_tag = "mid_reset";
      memen_cnt = 0; pops = 0; got_first = 1'b0; prev_stall = 1'b0;
      push_expected(vecs[5]);
      @(posedge clk_a); #1;
      drive_ar(vecs[5]);
      axi.rready_i = 1'b1;
      @(posedge clk_a); #1;
      axi.arvalid_i = 1'b0;
      guard = 0;
      while (pops < 3 && guard < 50) begin
         @(posedge clk_a); #1;
         guard++;
      end
      chk("mid_reset_reached_beat2", 64'(pops >= 3), 64'd1);
      mon_en   = 1'b0;
      resetn_a = 1'b0;
      #1;
      chk_reset_outputs();
      exp_q.delete();
      mem_q.delete();
      @(negedge clk_a);
      resetn_a = 1'b1;
      @(posedge clk_a); #1;
      chk("arready_after_mid_reset", 64'(axi.arready_o), 64'd1);
      mon_en  = 1'b1;
      cur_tag = "post_reset";
      run_vec(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_axi_rd_slave.md
# vga_axi_rd_slave

AXI4 read-channel responder that serves AR/R bursts out of a single-port synchronous frame memory. It is the subordinate end of the read interface issued by the VGA frame fetcher, used as the on-chip frame store in bring-up and as the bench model for that master. It supports FIXED, INCR and WRAP bursts, address-window decode (DECERR), and illegal-request detection (SLVERR). Full back-pressure on R is handled with a 2-entry output buffer while sustaining one beat per cycle.

## Interface
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 64, AXI/memory data width; power of two, 8..1024
- MEM_AW, 16, memory word-address width
- clk_a  input  1  clock; single clock domain
- resetn_a  input  1  reset, asynchronous, active-low
- win_base_i  input  ADDR_WIDTH  first byte address of decoded window; static during traffic
- win_top_i  input  ADDR_WIDTH  last byte address of window (inclusive); static during traffic
- arvalid_i  input  1  AR valid
- arready_o  output  1  AR ready
- araddr_i  input  ADDR_WIDTH  burst start byte address
- arburst_i  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- arlen_i  input  8  beats minus one
- arsize_i  input  3  log2 bytes per beat
- rvalid_o  output  1  R valid
- rready_i  input  1  R ready
- rdata_o  output  DATA_WIDTH  read data
- rresp_o  output  2  00 OKAY, 10 SLVERR, 11 DECERR
- rlast_o  output  1  last beat of burst
- mem_en_o  output  1  memory read strobe
- mem_addr_o  output  MEM_AW  memory word address
- mem_rdata_i  input  DATA_WIDTH  memory data; valid exactly one cycle after mem_en_o

## Operation
- States: IDLE, BURST. arready_o=1 only in IDLE.
- AR handshake (arvalid_i & arready_o) in IDLE: latch addr, len, size, and burst; clear beat-issue counter; go to BURST.
- Request error (whole burst gets SLVERR, memory not read): arburst=11; arsize > log2(DATA_WIDTH/8); WRAP with arlen not in {1,3,7,15}.
- Per-beat decode: addr < win_base_i or addr > win_top_i -> DECERR, rdata=0, no mem_en_o.
- OKAY beat: mem_en_o=1, mem_addr_o = ((addr - win_base_i) >> log2(DATA_WIDTH/8)) truncated to MEM_AW bits.
- Address advance after each issued beat: FIXED unchanged; INCR addr + (1<<size), ADDR_WIDTH modular; WRAP with span=(len+1)<<size, low bits wrap within a span-aligned block.
- Issue rule: a beat is issued when fifo_count + inflight - pop < 2, where pop = rvalid_o & rready_i. inflight is the beat issued last cycle.
- Output FIFO: 2 entries of {data, resp, last}. rvalid_o = FIFO not empty. R outputs come from the FIFO head.
- rlast_o=1 on beat index arlen.
- BURST -> IDLE on the cycle the last beat is popped. All beats of every burst are returned, including error bursts.

## Timing
- Reset values: arready_o=0, rvalid_o=0, rlast_o=0, rresp_o=00, rdata_o=0, mem_en_o=0, mem_addr_o=0. FIFO empty, state IDLE.
- arready_o is registered and goes to 1 on the first clk_a edge after resetn_a deasserts.
- AR handshake at edge N: first mem_en_o in cycle N+1, first rvalid_o in cycle N+2. Error beats have the same latency.
- With rready_i held high: one beat per cycle, so a burst of L beats has its last beat at N+1+L.
- R payload is stable while rvalid_o=1 and rready_i=0. rvalid_o never drops without a pop.
- arready_o returns to 1 the cycle after the rlast_o pop. A new AR is never accepted while a burst is open (single outstanding).
- Reset asserted mid-burst: immediate return to reset values; the in-flight burst is discarded.

## Structure
- Shared package vga_axi_pkg holds:
  - burst encodings (FIXED/INCR/WRAP)
  - resp encodings (OKAY/SLVERR/DECERR)
  - state enum
  - the beat-address-advance function, which is reused by the fetcher bench.
- One sub-module, vga_axi_rd_fifo: 2-entry synchronous FIFO with count output, same clock/reset.

## Test plan
- Window 0x1000-0x1FFF, memory word k = k. INCR araddr=0x1000, arlen=3, arsize=3, rready=1 -> rdata 0,1,2,3; rresp 00; rlast on beat 3; rvalid first at N+2.
- WRAP araddr=0x1010, arlen=3, arsize=3 -> word addresses 2,3,0,1; all OKAY.
- INCR araddr=0x1FF8, arlen=1, arsize=3 -> beat0 data 0x1FF (OKAY); beat1 rresp 11, rdata 0.
- arburst=11, arlen=2 -> 3 beats rresp 10, no mem_en_o; arsize=4 with 64-bit data -> SLVERR on all beats.
- INCR arlen=7 with rready toggling 1,0,0,1 repeating -> 8 beats in order, payload held while stalled, never more than 2 beats buffered.
- Reset asserted after beat 2 of arlen=7 -> all outputs 0 immediately. After release, arready=1 and a new burst returns correct data.
